// File: rtl/bus_arbiter4.sv
// Round-robin arbiter and sequencer for a shared WIDTH-bit 4:1 bus multiplexer.
// Grants one requester at a time, registers the selected word, and preempts long holders.
module bus_arbiter4 #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid,
    output logic             busy
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    // With preemption disabled the counter only needs to record "at least one cycle".
    localparam logic [HW-1:0] HOLD_SAT   = (MAX_HOLD < 1) ? HW'(1) : HW'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       last_q,  last_d;
    logic [HW-1:0]    hold_q,  hold_d;
    logic [3:0]       gnt_q,   gnt_d;
    logic [1:0]       sel_q,   sel_d;
    logic [WIDTH-1:0] bus_q,   bus_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;

    logic [3:0]       owner_mask;
    logic [3:0]       candidates;
    logic             any_candidate;
    logic [1:0]       winner;
    logic             at_limit;

    // First set bit of mask searching upward from base+1, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] mask);
        logic [7:0] doubled;
        logic [3:0] rotated;
        logic [1:0] offset;
        doubled = {mask, mask};
        rotated = 4'(doubled >> (3'(base) + 3'd1));
        offset  = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (rotated[j]) offset = 2'(j);
        end
        return base + offset + 2'd1;
    endfunction

    function automatic logic [WIDTH-1:0] mux4(input logic [1:0] s);
        logic [WIDTH-1:0] y;
        case (s)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
        return y;
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;

        // In GRANT the current owner is excluded so the winner is always a different requester.
        owner_mask    = 4'b0001 << last_q;
        candidates    = (state_q == GRANT) ? (req & ~owner_mask) : req;
        any_candidate = |candidates;
        winner        = rr_pick(last_q, candidates);
        at_limit      = (MAX_HOLD != 0) && (hold_q == HOLD_LIMIT);

        case (state_q)
            IDLE: begin
                if (any_candidate) begin
                    state_d = GRANT;
                    last_d  = winner;
                    sel_d   = winner;
                    gnt_d   = 4'b0001 << winner;
                    hold_d  = HW'(1);
                end
            end
            GRANT: begin
                if (!req[last_q] || (at_limit && any_candidate)) begin
                    if (any_candidate) begin
                        last_d = winner;
                        sel_d  = winner;
                        gnt_d  = 4'b0001 << winner;
                        hold_d = HW'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase

        bus_d   = mux4(sel_d);
        valid_d = |gnt_d;
        busy_d  = |gnt_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            hold_q  <= '0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            bus_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign bus_out   = bus_q;
    assign bus_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Self-checking bench for bus_arbiter4: directed scenarios plus randomized traffic
// compared every cycle against a behavioural round-robin model.
module tb_bus_arbiter4;

    localparam int WIDTH    = 16;
    localparam int MAX_HOLD = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req = 4'b0000;
    logic [WIDTH-1:0] a = '0, b = '0, c = '0, d = '0;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] bus_out;
    logic             bus_valid;
    logic             busy;

    int errors = 0;
    int checks = 0;

    // Behavioural model: owner index (-1 = idle), most recent owner, cycles held.
    int               m_owner;
    int               m_last;
    int               m_hold;
    int               m_sel;
    logic [WIDTH-1:0] m_bus;

    bus_arbiter4 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .gnt       (gnt),
        .sel       (sel),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_hold  = 0;
        m_sel   = 0;
        m_bus   = '0;
    endtask

    // First requester after position 'from' in circular order 0..3, or -1 if none.
    function automatic int next_after(input int from, input logic [3:0] mask);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_give(input int who);
        m_owner = who;
        m_last  = who;
        m_sel   = who;
        m_hold  = 1;
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] din [4];
        logic [3:0]       others;
        int               w;
        din    = '{a, b, c, d};
        others = req;
        if (m_owner >= 0) others[m_owner] = 1'b0;
        w = next_after(m_last, others);
        if (m_owner < 0) begin
            if (w >= 0) model_give(w);
        end else if (!req[m_owner]) begin
            if (w >= 0) model_give(w);
            else        m_owner = -1;
        end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD && w >= 0) begin
            model_give(w);
        end else if (m_hold < (MAX_HOLD == 0 ? 1 : MAX_HOLD)) begin
            m_hold++;
        end
        m_bus = din[m_sel];
    endtask

    task automatic compare_model(input string ctx);
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        check({ctx, ".gnt"},   gnt,       exp_gnt);
        check({ctx, ".sel"},   sel,       m_sel);
        check({ctx, ".bus"},   bus_out,   m_bus);
        check({ctx, ".valid"}, bus_valid, m_owner >= 0);
        check({ctx, ".busy"},  busy,      m_owner >= 0);
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(ctx);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_model("reset");
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock edge.
    task automatic async_reset_pulse(input string ctx);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_model(ctx);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        do_reset();

        // Single request from c.
        c   = 16'hBEEF;
        req = 4'b0100;
        step("single");
        check("single_gnt", gnt, 4'b0100);
        check("single_sel", sel, 2);
        check("single_bus", bus_out, 16'hBEEF);
        check("single_valid", bus_valid, 1);
        req = 4'b0000;
        step("release");
        check("release_gnt", gnt, 4'b0000);
        check("release_valid", bus_valid, 0);

        // All four at once after reset: order 0,1,2,3 back to back.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step("rr");
            check("rr_order", gnt, 4'b0001 << i);
            req[i] = 1'b0;
        end
        step("rr_end");
        check("rr_idle", gnt, 4'b0000);

        // Preemption: owner 0 held, requester 2 arrives in cycle 3.
        do_reset();
        req = 4'b0001;
        n   = 0;
        for (int t = 0; t < 30; t++) begin
            if (t == 2) req[2] = 1'b1;
            step("preempt");
            if (gnt == 4'b0001) n++;
            else break;
        end
        check("preempt_len", n, MAX_HOLD);
        check("preempt_next", gnt, 4'b0100);

        // Sole requester 1 keeps the bus indefinitely.
        req = 4'b0010;
        for (int t = 0; t < 20; t++) begin
            step("alone");
            check("alone_gnt", gnt, 4'b0010);
        end

        // Wrap-around from owner 3 back to 0.
        req = 4'b1000;
        step("wrap_setup");
        check("wrap_owner3", gnt, 4'b1000);
        req = 4'b0011;
        step("wrap");
        check("wrap_gnt", gnt, 4'b0001);
        check("wrap_sel", sel, 0);

        // Async reset in the middle of a grant to 1.
        req = 4'b0010;
        step("ar_setup");
        check("ar_owner1", gnt, 4'b0010);
        async_reset_pulse("ar");
        check("ar_gnt", gnt, 4'b0000);
        check("ar_bus", bus_out, 0);
        req = 4'b0110;
        step("ar_after");
        check("ar_after_gnt", gnt, 4'b0010);

        // Randomized traffic with occasional mid-cycle resets.
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            c = WIDTH'($urandom);
            d = WIDTH'($urandom);
            step("rand");
            if ($urandom_range(0, 299) == 0) async_reset_pulse("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter4.md
# bus_arbiter4

Round-robin arbiter and sequencer for the shared 16-bit 4:1 datapath multiplexer (Mux4x16). Four requesters present 16-bit data and a request line. The block grants the bus to one requester at a time and drives the mux select. It registers the selected word onto the shared bus output and bounds how long one owner may hold the bus while others wait.

## Interface
Parameters:
- WIDTH, 16, data width of each requester input and of bus_out.
- MAX_HOLD, 8, maximum consecutive granted cycles per owner while another request is pending; 0 = unlimited (no preemption).

Ports:
- clk  in  1  rising-edge clock; sole clock domain.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  request lines; req[i] for requester i (0=a, 1=b, 2=c, 3=d).
- a, b, c, d  in  WIDTH each  requester data words.
- gnt  out  4  one-hot grant, or all-zero when idle; registered.
- sel  out  2  mux select, drives Mux4x16 sel; equals the index of the current/last owner.
- bus_out  out  WIDTH  registered selected data.
- bus_valid  out  1  bus_out holds data captured under a grant.
- busy  out  1  high whenever gnt != 0.

## Operation
- State: IDLE (gnt=0) and GRANT (one gnt bit set).
- Pointer `last` is the 2-bit index of the most recent owner. Search order starts at last+1 and wraps modulo 4.
- Winner: the first i in search order with req[i]=1.
- hold_cnt: counts granted cycles of the current owner. It is cleared to 1 on each new grant, increments each GRANT cycle, and saturates at MAX_HOLD.
- IDLE:
  - If any req is set, go to GRANT with the winner: gnt one-hot, sel=winner, last=winner.
  - Otherwise stay in IDLE; sel holds its value.
- GRANT with owner o, evaluated at each edge:
  - req[o]=0, no other req: go to IDLE; gnt=0; sel unchanged.
  - req[o]=0, other req pending: hand off directly to the winner (search from o+1) with no idle cycle.
  - req[o]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD, and another req pending: preempt; grant passes to the winner in search order (o is excluded).
  - Otherwise: keep o and increment hold_cnt.
- Data path: each edge, bus_out <= input selected by the next-state sel; bus_valid <= |next gnt.
- A requester must hold req until granted. Dropping req before grant withdraws the request with no side effect.
- Simultaneous requests: round-robin order decides. After reset, priority is 0,1,2,3 because last resets to 3.
- MAX_HOLD=1 gives strict per-cycle rotation among all active requesters.

## Timing
- Reset (async assert, synchronous-effect release): gnt=0, sel=0, bus_out=0, bus_valid=0, busy=0, last=3, hold_cnt=0, state IDLE.
  - Assertion mid-grant clears all outputs immediately, without waiting for clk.
- Request latency: req sampled high at edge k gives gnt, sel and busy valid after edge k, and bus_out/bus_valid valid after edge k as well. The data is the input word present at edge k.
- Release latency: req[o] sampled low at edge k gives the new grant or IDLE after edge k. bus_valid drops after edge k when idle.
- Handoff: zero bubble cycles between owners.
- Contended owner receives exactly MAX_HOLD consecutive gnt cycles.
- gnt is never multi-hot. sel changes only on a grant edge.

## Test plan
- Single request: rst, then req=4'b0100 with c=16'hBEEF. Required: gnt=4'b0100 and sel=2 after the first edge; bus_out=16'hBEEF with bus_valid=1; release gives gnt=0 and bus_valid=0 one edge later.
- Simultaneous after reset: req=4'b1111, each requester dropping req after its own first granted cycle. Required: grant order 0,1,2,3 with back-to-back grants and no idle cycle.
- Preemption: MAX_HOLD=8, req[0] held and req[2] raised at cycle 3. Required: gnt[0] for exactly 8 cycles, then gnt=4'b0100 on the next edge.
- No preemption when alone: req[1] held 20 cycles with no other req. Required: gnt[1] continuous for 20 cycles, hold_cnt saturates, no glitch on gnt.
- Wrap-around: owner 3 releases while req=4'b0011. Required: next gnt=4'b0001, sel=0.
- Async reset mid-grant: rst pulsed between edges during gnt=4'b0010. Required: gnt=0, sel=0, bus_out=0, bus_valid=0 immediately. After release with req=4'b0110, gnt=4'b0010 because last=3 gives index 1 priority over 2.
